// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------+
// | mem_pkg : size encodings, FSM state type and size legality helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

   // RV32I funct3 load/store size encodings
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Stores have no unsigned variants, so only b/h/w are legal for them.
   function automatic logic size_ok(input logic write, input logic [2:0] size);
      logic signed_ok;
      signed_ok = (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
      if (write) begin
         return signed_ok;
      end
      return signed_ok || (size == SZ_BU) || (size == SZ_HU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +--------------------------------------------------------------------+
// | mem_lane_align : byte-lane select, store byte enables, load extend |
// | Optional: MEM_MISALIGN_CHECK_EN reports misaligned h/w accesses    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext,
   output logic        align_err
);

   logic [1:0]  off;
   logic [31:0] shifted;

   always_comb begin
      off       = addr_lo;
      byte_en   = 4'b0000;
      align_err = 1'b0;
      // Offending low bits are dropped so the access lands on its natural boundary.
      case (size[1:0])
         2'b00: begin
            byte_en = 4'b0001 << off;
         end
         2'b01: begin
`ifdef MEM_MISALIGN_CHECK_EN
            align_err = addr_lo[0];
`endif
            off[0]  = 1'b0;
            byte_en = 4'b0011 << off;
         end
         2'b10: begin
`ifdef MEM_MISALIGN_CHECK_EN
            align_err = |addr_lo;
`endif
            off     = 2'b00;
            byte_en = 4'b1111;
         end
         default: begin
            byte_en = 4'b0000;
         end
      endcase

      wdata_lanes = wdata << {off, 3'b000};
      shifted     = rword >> {off, 3'b000};

      case (size)
         SZ_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         SZ_W:    rdata_ext = shifted;
         SZ_BU:   rdata_ext = {24'd0, shifted[7:0]};
         SZ_HU:   rdata_ext = {16'd0, shifted[15:0]};
         default: rdata_ext = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// +--------------------------------------------------------------------+
// | mem_responder : single-outstanding memory slave with wait states   |
// | Optional: MEM_MISALIGN_CHECK_EN turns misaligned h/w into errors   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [2:0]    acc_size;
   logic [31:0]   acc_wdata;
   logic          acc_err;
   logic          in_range;
   logic          enter_resp;
   logic          mem_we;
   logic [AW-1:0] word_idx;
   logic [31:0]   rword;
   logic [3:0]    byte_en;
   logic [31:0]   wdata_lanes;
   logic [31:0]   rdata_ext;
   logic          align_err;

   // With no wait states the store commits on the accept edge, before capture.
   assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
   assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
   assign acc_size  = (state_q == ST_IDLE) ? req_size  : size_q;
   assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

   assign in_range = ({1'b0, acc_addr} < ADDR_LIMIT);
   assign acc_err  = !in_range || !size_ok(acc_write, acc_size) || align_err;
   assign word_idx = acc_addr[AW+1:2];
   assign rword    = mem[word_idx];

   mem_lane_align u_lane_align (
      .size        (acc_size),
      .addr_lo     (acc_addr[1:0]),
      .wdata       (acc_wdata),
      .rword       (rword),
      .byte_en     (byte_en),
      .wdata_lanes (wdata_lanes),
      .rdata_ext   (rdata_ext),
      .align_err   (align_err)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'd0;
      rsp_err_d   = 1'b0;
      enter_resp  = 1'b0;
      req_ready   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               size_d  = req_size;
               wdata_d = req_wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            // Response is registered, so it is seen the cycle after RESP.
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_write || acc_err) ? 32'd0 : rdata_ext;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         addr_q      <= 32'd0;
         size_q      <= 3'd0;
         wdata_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // A reset on the commit edge aborts the store.
   assign mem_we = enter_resp && acc_write && !acc_err && reset;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning memory size in 32-bit words; requests at or above DEPTH_WORDS*4 are out of range.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0-15, meaning added wait states per access.
REQ-003 SHALL have port clk, input, 1, the clock; every state change happens on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning the processor is presenting a request.
REQ-006 SHALL have port req_ready, output, 1, meaning the request is accepted this cycle.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load or fetch.
REQ-008 SHALL have port req_addr, input, 32, the byte address.
REQ-009 SHALL have port req_size, input, 3, using the RV32I funct3 load/store encoding.
REQ-010 SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, a one-cycle pulse marking access complete.
REQ-012 SHALL have port rsp_rdata, output, 32, the load data after extension.
REQ-013 SHALL have port rsp_err, output, 1, valid with rsp_valid, meaning the access failed.

Function
REQ-014 SHALL implement the states IDLE, WAIT and RESP.
REQ-015 SHALL hold req_ready=1 only in IDLE; a request is accepted when req_valid&req_ready, and write, addr, size and wdata are captured at that edge.
REQ-016 SHALL transition IDLE->WAIT on accept and load a wait counter with WAIT_CYCLES-1; if WAIT_CYCLES=0 it SHALL go IDLE->RESP directly.
REQ-017 SHALL decrement the wait counter in WAIT and go to RESP when the counter is 0.
REQ-018 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; for a request accepted at edge N, rsp_valid is high during the cycle after edge N+WAIT_CYCLES+1.
REQ-019 SHALL ignore req_valid outside IDLE and SHALL not queue it; the requester must hold the request until req_ready.
REQ-020 SHALL perform any store on the edge that enters RESP, writing only the byte lanes selected by size and addr[1:0] (sb: 1 lane, sh: 2 lanes, sw: all 4); other lanes remain unchanged.
REQ-021 SHALL read loads in RESP from the word at addr[31:2], shift the data by addr[1:0], and extend it: 000 lb sign, 001 lh sign, 010 lw, 100 lbu zero, 101 lhu zero.
REQ-022 SHALL treat req_size 011, 110 and 111 (and any size other than 000-010 on a store) as illegal: rsp_err=1, no write, rsp_rdata=0.
REQ-023 SHALL treat an out-of-range address as an error: rsp_err=1, no write, rsp_rdata=0; addresses never wrap.
REQ-024 SHALL drive rsp_rdata=0 on stores, and SHALL keep rsp_rdata and rsp_err at 0 whenever rsp_valid=0.

Reset
REQ-025 SHALL, while reset=0 at an edge, go to IDLE, clear the wait counter, and drive req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 from the next cycle.
REQ-026 SHALL abort an access that is in WAIT when reset is asserted: no store commits and no rsp_valid is issued.
REQ-027 SHALL not initialise memory contents on reset.

Configuration
REQ-028 SHALL, when MEM_MISALIGN_CHECK_EN is defined, flag a halfword with addr[0]=1 or a word with addr[1:0]!=0 as an error (rsp_err=1, no write, rsp_rdata=0).
REQ-029 SHALL, when MEM_MISALIGN_CHECK_EN is undefined, silently clear the offending low address bits and complete the access normally with rsp_err=0.

Structure
REQ-030 SHALL take the size-encoding constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the state typedef from a shared package, mem_pkg.
REQ-031 SHALL place lane select, store byte-enable generation and load extension in one combinational sub-module, mem_lane_align; the FSM, counter and storage SHALL stay in mem_responder.

Verification
REQ-032 SHALL be verified with: WAIT_CYCLES=2, sw 0xDEADBEEF to addr 0x10 accepted at edge 0 -> rsp_valid for exactly one cycle after edge 3; then lw 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 SHALL be verified with: after the sw above, lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
REQ-034 SHALL be verified with: sb 0x55 to 0x11 over 0xDEADBEEF -> a following lw 0x10 returns 0xDEAD55EF.
REQ-035 SHALL be verified with: lw 0x12 -> rsp_err=1 and rsp_rdata=0 with the macro defined; without it, the read returns word 0x10 with rsp_err=0.
REQ-036 SHALL be verified with: sw to DEPTH_WORDS*4 -> rsp_err=1 and word 0 is unchanged; req_size=011 -> rsp_err=1.
REQ-037 SHALL be verified with: reset=0 one cycle into WAIT of sw 0x1 to 0x20 -> no rsp_valid, req_ready=1 on the next cycle, and a later lw 0x20 returns the old value.
